// File: rtl/keypad_scanner_if.sv
// Pin-side bundle of the 4x3 keypad scanner: matrix drive/sense plus the committed-key outputs.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [9:0] keys;
  logic       key_strobe;
  logic       start_n;
  logic       clear_n;

  modport master (input row_n, output col_n, keys, key_strobe, start_n, clear_n);
  modport slave  (output row_n, input col_n, keys, key_strobe, start_n, clear_n);
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column drive, row sync, per-scan multi-press rejection, debounce, one-hot digit out.
// Optional macro KEYPAD_FUNC_KEYS_EN maps '#' to start_n and '*' to clear_n.
module keypad_scanner #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input logic         clk,
  input logic         rst_n,
  keypad_scanner_if.master kp
);
  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [3:0] K_STAR = 4'd10;
  localparam logic [3:0] K_HASH = 4'd11;
  localparam logic [3:0] K_NONE = 4'd15;

  typedef enum logic [1:0] {COL0, COL1, COL2} col_e;

  // Snapshot bit index is col*4+row.
  function automatic logic [3:0] key_at(input int idx);
    case (idx)
      0: key_at = 4'd1;  1: key_at = 4'd4;  2: key_at = 4'd7;  3: key_at = K_STAR;
      4: key_at = 4'd2;  5: key_at = 4'd5;  6: key_at = 4'd8;  7: key_at = 4'd0;
      8: key_at = 4'd3;  9: key_at = 4'd6;  10: key_at = 4'd9; 11: key_at = K_HASH;
      default: key_at = K_NONE;
    endcase
  endfunction

  function automatic logic [3:0] decode(input logic [11:0] snap);
    logic [3:0] k;
    int         n;
    k = K_NONE;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (snap[i]) begin
        n++;
        k = key_at(i);
      end
    end
    return (n == 1) ? k : K_NONE;
  endfunction

  function automatic logic [9:0] onehot(input logic [3:0] k);
    return (k <= 4'd9) ? (10'd1 << k) : 10'd0;
  endfunction

  logic [3:0]        row_s1_q, row_s2_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  col_e              col_q, col_d;
  logic [11:0]       snap_q, snap_d;
  logic              eval_q, eval_d;
  logic [3:0]        prev_q, prev_d, comm_q, comm_d, cand;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [9:0]        keys_q;
  logic              strobe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      slot_q   <= '0;
      col_q    <= COL0;
      eval_q   <= 1'b0;
      prev_q   <= K_NONE;
      comm_q   <= K_NONE;
      cnt_q    <= '0;
      keys_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      row_s1_q <= kp.row_n;
      row_s2_q <= row_s1_q;
      slot_q   <= slot_d;
      col_q    <= col_d;
      eval_q   <= eval_d;
      prev_q   <= prev_d;
      comm_q   <= comm_d;
      cnt_q    <= cnt_d;
      keys_q   <= onehot(comm_d);
      strobe_q <= (comm_d != comm_q) && (comm_d <= 4'd9);
    end
  end

  // Snapshot is fully rewritten before each evaluation, so it needs no reset.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  always_comb begin
    slot_d = slot_q;
    col_d  = col_q;
    snap_d = snap_q;
    eval_d = 1'b0;
    prev_d = prev_q;
    cnt_d  = cnt_q;
    comm_d = comm_q;
    cand   = decode(snap_q);
    if (slot_q == SLOT_LAST) begin
      slot_d = '0;
      unique case (col_q)
        COL0: begin snap_d[3:0]  = ~row_s2_q; col_d = COL1; end
        COL1: begin snap_d[7:4]  = ~row_s2_q; col_d = COL2; end
        COL2: begin snap_d[11:8] = ~row_s2_q; col_d = COL0; eval_d = 1'b1; end
        default: col_d = COL0;
      endcase
    end else begin
      slot_d = slot_q + 1'b1;
    end
    if (eval_q) begin
      if (cand == prev_q) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else begin
        prev_d = cand;
        cnt_d  = CNT_W'(1);
      end
      if ((cnt_d == CNT_MAX) && (cand != comm_q)) comm_d = cand;
    end
  end

  always_comb begin
    unique case (col_q)
      COL0:    kp.col_n = 3'b110;
      COL1:    kp.col_n = 3'b101;
      COL2:    kp.col_n = 3'b011;
      default: kp.col_n = 3'b110;
    endcase
  end

  assign kp.keys       = keys_q;
  assign kp.key_strobe = strobe_q;

`ifdef KEYPAD_FUNC_KEYS_EN
  logic start_q, clear_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b1;
      clear_q <= 1'b1;
    end else begin
      start_q <= (comm_d != K_HASH);
      clear_q <= (comm_d != K_STAR);
    end
  end

  assign kp.start_n = start_q;
  assign kp.clear_n = clear_q;
`else
  assign kp.start_n = 1'b1;
  assign kp.clear_n = 1'b1;
`endif
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: matrix keypad model, directed press/release/multi/reset phases, then random phases.
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_scanner_if kp();
  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (.clk(clk), .rst_n(rst_n), .kp(kp));

  // press bit index is row*3+col
  logic [11:0] press = '0;

  function automatic logic [3:0] rows_of(input logic [11:0] p, input logic [2:0] col_n);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ~|(p[i*3 +: 3] & ~col_n);
    return r;
  endfunction
  assign kp.row_n = rows_of(press, kp.col_n);

  int errors = 0;
  int checks = 0;
  int nstrobe = 0;
  int cur_key = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (kp.key_strobe === 1'b1) nstrobe++;
  endtask

  // Printed label of key (row,col): 0-9 digits, 10 '*', 11 '#'
  function automatic int label(input int idx);
    if (idx < 9) return idx + 1;
    if (idx == 9) return 10;
    if (idx == 10) return 0;
    return 11;
  endfunction

  function automatic int expect_key(input logic [11:0] s);
    int k;
    k = -1;
    if ($countones(s) == 1)
      for (int i = 0; i < 12; i++) if (s[i]) k = label(i);
    return k;
  endfunction

  function automatic logic [9:0] exp_keys(input int k);
    if (k >= 0 && k <= 9) return 10'd1 << k;
    return 10'd0;
  endfunction

  task automatic run_phase(input logic [11:0] s, input int bounce, input string tag);
    logic [11:0] old;
    int k_new, first, exp_str, exp_start, exp_clear;
    old = press;
    k_new = expect_key(s);
    nstrobe = 0;
    first = -1;
    for (int i = 0; i < bounce; i++) begin
      press = ($urandom_range(0, 1) == 1) ? s : old;
      tick();
    end
    press = s;
    for (int n = 1; n <= 70; n++) begin
      tick();
      if (first < 0 && kp.keys === exp_keys(k_new)) first = n;
    end
    exp_str = (k_new >= 0 && k_new <= 9 && k_new != cur_key) ? 1 : 0;
`ifdef KEYPAD_FUNC_KEYS_EN
    exp_start = (k_new == 11) ? 0 : 1;
    exp_clear = (k_new == 10) ? 0 : 1;
`else
    exp_start = 1;
    exp_clear = 1;
`endif
    chk({tag, "_latency_ok"}, 32'(first >= 1 && first <= 51), 32'd1);
    chk({tag, "_keys"}, 32'(kp.keys), 32'(exp_keys(k_new)));
    chk({tag, "_strobes"}, 32'(nstrobe), 32'(exp_str));
    chk({tag, "_start_n"}, 32'(kp.start_n), 32'(exp_start));
    chk({tag, "_clear_n"}, 32'(kp.clear_n), 32'(exp_clear));
    cur_key = k_new;
  endtask

  initial begin
    logic [11:0] s;
    int a, b;
    repeat (3) tick();
    chk("rst_col_n", 32'(kp.col_n), 32'h6);
    chk("rst_keys", 32'(kp.keys), 32'h0);
    chk("rst_strobe", 32'(kp.key_strobe), 32'h0);
    chk("rst_start_n", 32'(kp.start_n), 32'h1);
    chk("rst_clear_n", 32'(kp.clear_n), 32'h1);
    rst_n = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 1)  chk("col_step0", 32'(kp.col_n), 32'h6);
      if (k == 5)  chk("col_step1", 32'(kp.col_n), 32'h5);
      if (k == 9)  chk("col_step2", 32'(kp.col_n), 32'h3);
      if (k == 13) chk("col_step3", 32'(kp.col_n), 32'h6);
    end

    run_phase(12'd1 << 4, 0, "press5");
    run_phase(12'd0, 0, "release5");
    run_phase((12'd1 << 1) | (12'd1 << 7), 0, "multi2_8");
    run_phase(12'd1 << 1, 0, "only2");
    run_phase(12'd0, 0, "release2");
    run_phase(12'd1 << 0, 6, "bounce1");
    run_phase(12'd1 << 10, 0, "press0");
    run_phase(12'd1 << 11, 0, "hash");
    run_phase(12'd1 << 9, 0, "star");
    run_phase(12'd0, 0, "release_star");
    run_phase(12'd1 << 8, 0, "press9");

    // Asynchronous reset while '9' is held
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_keys", 32'(kp.keys), 32'h0);
    chk("midrst_strobe", 32'(kp.key_strobe), 32'h0);
    chk("midrst_col_n", 32'(kp.col_n), 32'h6);
    repeat (3) tick();
    rst_n = 1'b1;
    cur_key = -1;
    run_phase(press, 0, "rehold9");

    for (int p = 0; p < 20; p++) begin
      a = $urandom_range(0, 11);
      b = $urandom_range(0, 11);
      case ($urandom_range(0, 3))
        0: s = '0;
        3: s = (12'd1 << a) | (12'd1 << ((a + 1 + b % 11) % 12));
        default: s = 12'd1 << a;
      endcase
      run_phase(s, $urandom_range(0, 8), $sformatf("rnd%0d", p));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
